bcd_serial_addsub: RTL and testbench

//  Multi-digit packed-BCD adder/subtractor, digit-serial: one BCD digit per clock through a single

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_digit_add.sv | 24 ++
 rtl/bcd_serial_addsub.sv | 156 +++++++++++++++
 tb/tb_bcd_serial_addsub.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants for the digit-serial BCD adder/subtractor.
package bcd_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder with the classic +6 decimal correction.
module bcd_digit_add (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] d,
  output logic       cout
);

  logic [4:0] s;

  // Binary add, then fold anything above 9 back into a decimal digit plus carry
  always_comb begin
    s = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    if (s > 5'd9) begin
      d    = s[3:0] + 4'd6;
      cout = 1'b1;
    end else begin
      d    = s[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor. One digit per clock through a
// shared digit adder; negative subtract results get a second 10's-complement
// pass so the result is always sign + magnitude.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                carry_in,
  output logic                ready,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                carry_out,
  output logic                negative,
  output logic                invalid
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] index;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             mode_reg;
  logic             carry;

  logic [3:0] a_dig;
  logic [3:0] b_dig;
  logic [3:0] s_dig;
  logic [3:0] x_op;
  logic [3:0] y_op;
  logic [3:0] d_out;
  logic       c_out;
  logic       bad_digit;

  assign ready = (state == ST_IDLE);
  assign done  = (state == ST_DONE);

  // Select the current digit of each operand and of the partial result
  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    s_dig = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      if (index == CNT_W'(k)) begin
        a_dig = a_reg[4*k +: 4];
        b_dig = b_reg[4*k +: 4];
        s_dig = sum[4*k +: 4];
      end
    end
  end

  // Flag any non-decimal digit on the incoming operands
  always_comb begin
    bad_digit = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if ((a[4*k +: 4] > BCD_MAX) || (b[4*k +: 4] > BCD_MAX)) begin
        bad_digit = 1'b1;
      end
    end
  end

  // Operand mux for the shared digit adder: a+b or a+(9-b) in ADD, (9-sum)+carry in FIX
  always_comb begin
    if (state == ST_FIX) begin
      x_op = BCD_MAX - s_dig;
      y_op = 4'd0;
    end else begin
      x_op = a_dig;
      y_op = (mode_reg == MODE_SUB) ? (BCD_MAX - b_dig) : b_dig;
    end
  end

  bcd_digit_add u_digit_add (
    .x    (x_op),
    .y    (y_op),
    .cin  (carry),
    .d    (d_out),
    .cout (c_out)
  );

  // Control FSM, digit counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      index     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      mode_reg  <= MODE_ADD;
      carry     <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      negative  <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            mode_reg  <= mode;
            sum       <= '0;
            carry_out <= 1'b0;
            negative  <= 1'b0;
            index     <= '0;
            if (bad_digit) begin
              invalid <= 1'b1;
              state   <= ST_DONE;
            end else begin
              invalid <= 1'b0;
              carry   <= (mode == MODE_SUB) ? 1'b1 : carry_in;
              state   <= ST_ADD;
            end
          end
        end
        ST_ADD, ST_FIX: begin
          for (int k = 0; k < DIGITS; k++) begin
            if (index == CNT_W'(k)) begin
              sum[4*k +: 4] <= d_out;
            end
          end
          carry <= c_out;
          if (index == LAST_IDX) begin
            index <= '0;
            if (state == ST_FIX) begin
              state <= ST_DONE;
            end else if (mode_reg == MODE_ADD) begin
              carry_out <= c_out;
              state     <= ST_DONE;
            end else if (c_out) begin
              state <= ST_DONE;
            end else begin
              negative <= 1'b1;
              carry    <= 1'b1;
              state    <= ST_FIX;
            end
          end else begin
            index <= index + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub (DIGITS=4): directed table,
// hand-written busy/reset sequences, and random ops against a decimal model.
module tb_bcd_serial_addsub;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         ready;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         negative;
  logic         invalid;

  int total;
  int bad;

  logic [W-1:0] gotSum;
  logic         gotCout;
  logic         gotNeg;
  logic         gotInv;
  int           gotLat;
  logic         gotDone;

  typedef struct {
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         neg;
    logic         inv;
    int           lat;
  } vec_t;

  vec_t vecs[11];

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .ready     (ready),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .negative  (negative),
    .invalid   (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int bcdToInt(input logic [W-1:0] v);
    int r;
    logic [3:0] dg;
    r = 0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      dg = v[4*k +: 4];
      r = r * 10 + int'(dg);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] intToBcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic hasBad(input logic [W-1:0] v);
    logic [3:0] dg;
    for (int k = 0; k < DIGITS; k++) begin
      dg = v[4*k +: 4];
      if (dg > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Decimal reference: plain integer arithmetic on the operand values
  function automatic void refModel(input logic m, input logic [W-1:0] va, input logic [W-1:0] vb,
                                   input logic vc, output logic [W-1:0] es, output logic ec,
                                   output logic en, output logic ei, output int el);
    int ia, ib, r, lim;
    lim = 1;
    for (int k = 0; k < DIGITS; k++) lim = lim * 10;
    es = '0; ec = 1'b0; en = 1'b0; ei = 1'b0;
    if (hasBad(va) || hasBad(vb)) begin
      ei = 1'b1;
      el = 1;
      return;
    end
    ia = bcdToInt(va);
    ib = bcdToInt(vb);
    el = DIGITS + 1;
    if (!m) begin
      r  = ia + ib + int'(vc);
      ec = (r >= lim);
      es = intToBcd(r % lim);
    end else if (ia >= ib) begin
      es = intToBcd(ia - ib);
    end else begin
      es = intToBcd(ib - ia);
      en = 1'b1;
      el = 2 * DIGITS + 1;
    end
  endfunction

  // Wait for ready, launch one op, then follow it to done; poke>0 re-pulses start mid-op
  task automatic applyStimulus(input logic m, input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic vc, input int poke);
    int waitCnt;
    waitCnt = 0;
    while (!ready && waitCnt < 50) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    mode     = m;
    a        = va;
    b        = vb;
    carry_in = vc;
    start    = 1'b1;
    gotLat   = 0;
    gotDone  = 1'b0;
    while (!gotDone && gotLat < 40) begin
      @(posedge clk); #1;
      gotLat++;
      start = 1'b0;
      if (poke != 0 && gotLat == poke) begin
        start = 1'b1;
        a     = 16'h1111;
        b     = 16'h1111;
        mode  = 1'b0;
      end
      if (done) begin
        gotDone = 1'b1;
        gotSum  = sum;
        gotCout = carry_out;
        gotNeg  = negative;
        gotInv  = invalid;
      end
    end
    start = 1'b0;
    if (!gotDone) checkOutput("done_timeout", 32'(gotDone), 32'd1);
  endtask

  task automatic runAndCheck(input string tag, input logic m, input logic [W-1:0] va,
                             input logic [W-1:0] vb, input logic vc, input int poke);
    logic [W-1:0] es;
    logic ec, en, ei;
    int el;
    refModel(m, va, vb, vc, es, ec, en, ei, el);
    applyStimulus(m, va, vb, vc, poke);
    if (gotDone) begin
      checkOutput({tag, "_sum"}, 32'(gotSum), 32'(es));
      checkOutput({tag, "_cout"}, 32'(gotCout), 32'(ec));
      checkOutput({tag, "_neg"}, 32'(gotNeg), 32'(en));
      checkOutput({tag, "_inv"}, 32'(gotInv), 32'(ei));
      checkOutput({tag, "_lat"}, 32'(gotLat), 32'(el));
    end
  endtask

  initial begin
    int seen;
    logic [W-1:0] ra, rb;
    logic [3:0] dg;
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    mode     = 1'b0;
    a        = '0;
    b        = '0;
    carry_in = 1'b0;

    vecs[0]  = '{1'b0, 16'h0042, 16'h0039, 1'b0, 16'h0081, 1'b0, 1'b0, 1'b0, 5};
    vecs[1]  = '{1'b0, 16'h9999, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 5};
    vecs[2]  = '{1'b0, 16'h0006, 16'h0009, 1'b0, 16'h0015, 1'b0, 1'b0, 1'b0, 5};
    vecs[3]  = '{1'b1, 16'h0100, 16'h0250, 1'b0, 16'h0150, 1'b0, 1'b1, 1'b0, 9};
    vecs[4]  = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 5};
    vecs[5]  = '{1'b0, 16'h00A1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1};
    vecs[6]  = '{1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 5};
    vecs[7]  = '{1'b1, 16'h5000, 16'h0001, 1'b1, 16'h4999, 1'b0, 1'b0, 1'b0, 5};
    vecs[8]  = '{1'b1, 16'h0000, 16'h9999, 1'b0, 16'h9999, 1'b0, 1'b1, 1'b0, 9};
    vecs[9]  = '{1'b0, 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0, 5};
    vecs[10] = '{1'b1, 16'h0000, 16'hF000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].cin, 0);
      if (gotDone) begin
        checkOutput($sformatf("vec%0d_sum", i), 32'(gotSum), 32'(vecs[i].sum));
        checkOutput($sformatf("vec%0d_cout", i), 32'(gotCout), 32'(vecs[i].cout));
        checkOutput($sformatf("vec%0d_neg", i), 32'(gotNeg), 32'(vecs[i].neg));
        checkOutput($sformatf("vec%0d_inv", i), 32'(gotInv), 32'(vecs[i].inv));
        checkOutput($sformatf("vec%0d_lat", i), 32'(gotLat), 32'(vecs[i].lat));
      end
    end

    // Start pulsed while busy, then again during the done cycle: both ignored
    applyStimulus(1'b1, 16'h0100, 16'h0250, 1'b0, 3);
    if (gotDone) begin
      checkOutput("busy_sum", 32'(gotSum), 32'h0150);
      checkOutput("busy_neg", 32'(gotNeg), 32'd1);
      checkOutput("busy_lat", 32'(gotLat), 32'd9);
    end
    start = 1'b1;
    a     = 16'h1111;
    b     = 16'h1111;
    mode  = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("donepoke_done", 32'(done), 32'd0);
    checkOutput("donepoke_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    checkOutput("hold_ready", 32'(ready), 32'd1);
    checkOutput("hold_sum", 32'(sum), 32'h0150);
    checkOutput("hold_neg", 32'(negative), 32'd1);

    // Reset two cycles into ADD aborts with no done pulse
    mode     = 1'b0;
    a        = 16'h1111;
    b        = 16'h1111;
    carry_in = 1'b0;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    checkOutput("abort_sum", 32'(sum), 32'd0);
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_cout", 32'(carry_out), 32'd0);
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    checkOutput("abort_nodone", 32'(seen), 32'd0);
    runAndCheck("after_abort", 1'b0, 16'h0042, 16'h0039, 1'b0, 0);

    // Random ops against the decimal model
    for (int n = 0; n < 60; n++) begin
      ra = '0;
      rb = '0;
      for (int k = 0; k < DIGITS; k++) begin
        dg = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        ra[4*k +: 4] = dg;
        dg = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        rb[4*k +: 4] = dg;
      end
      runAndCheck($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), ra, rb,
                  1'($urandom_range(0, 1)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
